branch_target_predictor: RTL and testbench
==========================================

// Module: branch_target_predictor
// PURPOSE
//  Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.
//  Successor to the fixed decode-stage branch resolution in the 5-stage pipeline. Lets IF redirect
//  NPC speculatively on the cycle an instruction is fetched.
//  Resolution in ID/EX trains the table through the update port. Also carries saturating
//  performance counters.
// PARAMETERS
//  XLEN     32  address/data width
//  ENTRIES  16  table depth; power of 2, >=2; IDX_W=log2(ENTRIES)
//  CNT_W     2  direction counter width, >=1; taken when counter MSB=1
//  PERF_W   32  width of performance counters
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low
//  lu_pc          in   XLEN    fetch PC to predict
//  pred_hit       out  1       valid entry with matching tag exists for lu_pc
//  pred_taken     out  1       pred_hit & counter MSB
//  pred_target    out  XLEN    stored target; 0 when !pred_hit
//  upd_valid      in   1       resolved branch/jump presented this cycle
//  upd_pc         in   XLEN    PC of resolved instruction
//  upd_taken      in   1       actual direction
//  upd_target     in   XLEN    actual target (meaningful when upd_taken)
//  upd_mispred    in   1       pipeline flushed due to wrong prediction
//  flush_all      in   1       invalidate every entry (context switch / self-modifying code)
//  perf_lookups   out  PERF_W  count of upd_valid cycles
//  perf_mispred   out  PERF_W  count of upd_valid & upd_mispred cycles
// BEHAVIOUR
//  Index/tag
//   - idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
//  Lookup
//   - Purely combinational from the current table; zero-cycle latency.
//   - No bypass from an update in the same cycle: lookup sees pre-edge contents.
//  Entry state
//   - Each entry holds valid, tag, target, cnt.
//   - Reset: all valid=0, cnt=0, tag=0, target=0. Perf counters=0.
//   - All outputs are 0 while reset is low.
//  Update (at the clock edge when upd_valid=1)
//   - Hit, taken: cnt=min(cnt+1, 2^CNT_W-1); target<=upd_target.
//   - Hit, not taken: cnt=max(cnt-1, 0). Entry stays valid; target unchanged.
//   - Miss, taken: allocate or overwrite the entry at idx (alias eviction).
//     valid=1, tag=new, target=upd_target, cnt=2^(CNT_W-1) (weakly taken).
//   - Miss, not taken: no table change.
//  Flush
//   - flush_all=1 clears every valid bit at the next edge; cnt, tag and target are don't-care.
//   - flush_all and upd_valid in the same cycle: flush wins, no allocation.
//     Perf counters still count the update.
//  Perf counters
//   - perf_lookups += upd_valid; perf_mispred += upd_valid & upd_mispred.
//   - Both saturate at all-ones; they never wrap.
//   - Neither counter is cleared by flush_all; only reset clears them.
//  Reset mid-operation
//   - Asserting reset clears the table and counters immediately (asynchronous).
//   - The first valid update is accepted on the first rising edge after deassertion.
//  Back-to-back updates to the same idx: each edge applies on top of the previous result.
//  Holds no pipeline state of its own. Stalls are the caller's responsibility: hold upd_valid low.
// TESTING
//  1 Reset low, lu_pc=0x0040_0010
//    -> pred_hit=0, pred_target=0, perf_*=0.
//  2 Update pc=0x0040_0010 taken target=0x0040_0100; next cycle lu_pc=0x0040_0010
//    -> hit=1, taken=1, target=0x0040_0100.
//  3 Same pc, three not-taken updates
//    -> cnt 2->1->0->0 (saturates); pred_taken=0 after the first; hit stays 1.
//  4 Alias pc=0x0040_0050 (same idx, ENTRIES=16) taken target=0x0040_0200
//    -> 0x0040_0010 misses; 0x0040_0050 hits with target 0x0040_0200.
//  5 flush_all with a simultaneous taken update to a new pc
//    -> next cycle every lookup misses; perf_lookups incremented by 1.
//  6 PERF_W=4: 20 updates with upd_mispred=1
//    -> perf_lookups=perf_mispred=15 (saturated). Async reset mid-run -> both 0 immediately.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup, resolution-side update and performance counter bundle
// shared between the pipeline and the branch target predictor.
interface branch_target_predictor_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned PERF_W = 32
);
   logic [XLEN-1:0]   lu_pc;
   logic              pred_hit;
   logic              pred_taken;
   logic [XLEN-1:0]   pred_target;
   logic              upd_valid;
   logic [XLEN-1:0]   upd_pc;
   logic              upd_taken;
   logic [XLEN-1:0]   upd_target;
   logic              upd_mispred;
   logic              flush_all;
   logic [PERF_W-1:0] perf_lookups;
   logic [PERF_W-1:0] perf_mispred;

   modport master (
      output lu_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, flush_all,
      input  pred_hit, pred_taken, pred_target, perf_lookups, perf_mispred
   );

   modport slave (
      input  lu_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred, flush_all,
      output pred_hit, pred_taken, pred_target, perf_lookups, perf_mispred
   );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters and
// saturating performance counters; lookup is combinational from the table.
module branch_target_predictor #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned CNT_W   = 2,
   parameter int unsigned PERF_W  = 32
) (
   input logic                      clk,
   input logic                      reset,
   branch_target_predictor_if.slave bus
);
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = XLEN - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

   logic              valid_q  [ENTRIES];
   logic              valid_d  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [TAG_W-1:0]  tag_d    [ENTRIES];
   logic [XLEN-1:0]   target_q [ENTRIES];
   logic [XLEN-1:0]   target_d [ENTRIES];
   logic [CNT_W-1:0]  cnt_q    [ENTRIES];
   logic [CNT_W-1:0]  cnt_d    [ENTRIES];
   logic [PERF_W-1:0] perf_lookups_q, perf_lookups_d;
   logic [PERF_W-1:0] perf_mispred_q, perf_mispred_d;

   logic [IDX_W-1:0]  lu_idx, upd_idx;
   logic [TAG_W-1:0]  lu_tag, upd_tag;
   logic              lu_hit, upd_hit;

   assign lu_idx  = bus.lu_pc[IDX_W+1:2];
   assign lu_tag  = bus.lu_pc[XLEN-1:IDX_W+2];
   assign upd_idx = bus.upd_pc[IDX_W+1:2];
   assign upd_tag = bus.upd_pc[XLEN-1:IDX_W+2];

   // Lookup reads pre-edge table contents; an update in the same cycle is not bypassed.
   assign lu_hit           = reset && valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
   assign upd_hit          = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
   assign bus.pred_hit     = lu_hit;
   assign bus.pred_taken   = lu_hit && cnt_q[lu_idx][CNT_W-1];
   assign bus.pred_target  = lu_hit ? target_q[lu_idx] : '0;
   assign bus.perf_lookups = perf_lookups_q;
   assign bus.perf_mispred = perf_mispred_q;

   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      cnt_d    = cnt_q;
      // Flush takes priority over any update presented in the same cycle.
      if (bus.flush_all) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_d[i] = 1'b0;
         end
      end else if (bus.upd_valid) begin
         if (upd_hit) begin
            if (bus.upd_taken) begin
               if (cnt_q[upd_idx] != CNT_MAX) cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
               target_d[upd_idx] = bus.upd_target;
            end else if (cnt_q[upd_idx] != '0) begin
               cnt_d[upd_idx] = cnt_q[upd_idx] - 1'b1;
            end
         end else if (bus.upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = bus.upd_target;
            cnt_d[upd_idx]    = CNT_WEAK;
         end
      end
   end

   always_comb begin
      perf_lookups_d = perf_lookups_q;
      perf_mispred_d = perf_mispred_q;
      if (bus.upd_valid && (perf_lookups_q != '1)) perf_lookups_d = perf_lookups_q + 1'b1;
      if (bus.upd_valid && bus.upd_mispred && (perf_mispred_q != '1)) begin
         perf_mispred_d = perf_mispred_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
         perf_lookups_q <= '0;
         perf_mispred_q <= '0;
      end else begin
         valid_q        <= valid_d;
         tag_q          <= tag_d;
         target_q       <= target_d;
         cnt_q          <= cnt_d;
         perf_lookups_q <= perf_lookups_d;
         perf_mispred_q <= perf_mispred_d;
      end
   end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: a default instance for table
// behaviour and a PERF_W=4 instance for counter saturation.
module tb_branch_target_predictor;
   logic clk = 1'b0;
   logic reset;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned exp_look = 0;
   int unsigned exp_mis  = 0;

   branch_target_predictor_if #(.XLEN(32), .PERF_W(32)) bus  ();
   branch_target_predictor_if #(.XLEN(32), .PERF_W(4))  bus4 ();

   branch_target_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2), .PERF_W(32)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   branch_target_predictor #(.XLEN(32), .ENTRIES(16), .CNT_W(2), .PERF_W(4)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                      input logic mis);
      bus.upd_valid   = 1'b1;
      bus.upd_pc      = pc;
      bus.upd_taken   = taken;
      bus.upd_target  = tgt;
      bus.upd_mispred = mis;
      tick();
      bus.upd_valid   = 1'b0;
      bus.upd_mispred = 1'b0;
      exp_look++;
      if (mis) exp_mis++;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                       input logic taken, input logic [31:0] tgt);
      bus.lu_pc = pc;
      #1;
      check({tag, "_hit"}, 64'(bus.pred_hit), 64'(hit));
      check({tag, "_taken"}, 64'(bus.pred_taken), 64'(taken));
      check({tag, "_target"}, 64'(bus.pred_target), 64'(tgt));
   endtask

   initial begin
      reset = 1'b0;
      bus.lu_pc = 32'h0040_0010; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
      bus.upd_target = '0; bus.upd_mispred = 1'b0; bus.flush_all = 1'b0;
      bus4.lu_pc = '0; bus4.upd_valid = 1'b0; bus4.upd_pc = '0; bus4.upd_taken = 1'b0;
      bus4.upd_target = '0; bus4.upd_mispred = 1'b0; bus4.flush_all = 1'b0;

      // 1: reset state
      #3;
      look("rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
      check("rst_perf_look", 64'(bus.perf_lookups), 64'd0);
      check("rst_perf_mis", 64'(bus.perf_mispred), 64'd0);
      check("rst_perf4_look", 64'(bus4.perf_lookups), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      // 2: allocate weakly taken
      upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1);
      look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
      check("alloc_perf_look", 64'(bus.perf_lookups), 64'(exp_look));

      // 3: counter walk down, saturate at 0, up, saturate at max
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b1);
      look("nt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
      look("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
      look("nt3_sat0", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0100);
      upd(32'h0040_0010, 1'b1, 32'h0040_0104, 1'b0);
      look("t1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0104);
      upd(32'h0040_0010, 1'b1, 32'h0040_0104, 1'b1);
      look("t2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
      upd(32'h0040_0010, 1'b1, 32'h0040_0104, 1'b0);
      upd(32'h0040_0010, 1'b1, 32'h0040_0104, 1'b0);
      look("t_sat3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
      look("nt_from3", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0104);
      upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
      look("nt_to1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0104);
      check("mid_perf_mis", 64'(bus.perf_mispred), 64'(exp_mis));

      // miss + not taken leaves the table alone
      upd(32'h0040_0020, 1'b0, 32'h0040_0999, 1'b0);
      look("miss_nt", 32'h0040_0020, 1'b0, 1'b0, 32'h0);

      // no bypass: lookup in the update cycle sees the old table
      bus.upd_valid = 1'b1; bus.upd_pc = 32'h0040_0060; bus.upd_taken = 1'b1;
      bus.upd_target = 32'h0040_0300; bus.lu_pc = 32'h0040_0060;
      #1;
      check("nobypass_hit", 64'(bus.pred_hit), 64'd0);
      tick();
      bus.upd_valid = 1'b0;
      exp_look++;
      look("after_bypass", 32'h0040_0060, 1'b1, 1'b1, 32'h0040_0300);

      // 4: alias eviction on shared index 4
      upd(32'h0040_0050, 1'b1, 32'h0040_0200, 1'b0);
      look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0);
      look("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0200);

      // 5: flush wins over a simultaneous allocation, but is still counted
      bus.flush_all = 1'b1;
      upd(32'h0040_0080, 1'b1, 32'h0040_0400, 1'b0);
      bus.flush_all = 1'b0;
      look("flush_a", 32'h0040_0050, 1'b0, 1'b0, 32'h0);
      look("flush_b", 32'h0040_0060, 1'b0, 1'b0, 32'h0);
      look("flush_c", 32'h0040_0080, 1'b0, 1'b0, 32'h0);
      check("flush_perf_look", 64'(bus.perf_lookups), 64'(exp_look));
      upd(32'h0040_0080, 1'b1, 32'h0040_0400, 1'b0);
      look("post_flush", 32'h0040_0080, 1'b1, 1'b1, 32'h0040_0400);

      // 6: 4-bit perf counters saturate at 15
      bus4.upd_valid = 1'b1; bus4.upd_mispred = 1'b1; bus4.upd_taken = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            check("p4_look_14", 64'(bus4.perf_lookups), 64'd14);
            check("p4_mis_14", 64'(bus4.perf_mispred), 64'd14);
         end
      end
      check("p4_look_sat", 64'(bus4.perf_lookups), 64'd15);
      check("p4_mis_sat", 64'(bus4.perf_mispred), 64'd15);
      bus4.upd_valid = 1'b0; bus4.upd_mispred = 1'b0;

      // asynchronous reset away from any clock edge
      #2;
      reset = 1'b0;
      #1;
      check("areset_p4_look", 64'(bus4.perf_lookups), 64'd0);
      check("areset_p4_mis", 64'(bus4.perf_mispred), 64'd0);
      check("areset_perf_look", 64'(bus.perf_lookups), 64'd0);
      look("areset_tbl", 32'h0040_0080, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      exp_look = 0;
      exp_mis  = 0;
      upd(32'h0040_0080, 1'b1, 32'h0040_0500, 1'b1);
      look("first_after_rst", 32'h0040_0080, 1'b1, 1'b1, 32'h0040_0500);
      check("rst_perf_look2", 64'(bus.perf_lookups), 64'(exp_look));
      check("rst_perf_mis2", 64'(bus.perf_mispred), 64'(exp_mis));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
